mem_write_buffer: RTL

- Posted-write buffer between the direct-mapped write-through cache's memory-side port and a multi-cycle main memory.
- Absorbs write-through traffic into a small FIFO so cache writes normally complete without stalling.
- Forwards buffered data to cache read misses and serialises reads and buffered writes onto a single req/ack memory port.
- Its busy output feeds the cache's stall path.

---
 rtl/mem_write_buffer_pkg.sv | 21 ++
 rtl/mem_write_buffer_fifo.sv | 86 ++++++++
 rtl/mem_write_buffer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_write_buffer_pkg.sv
// Shared types and defaults for the posted-write buffer.
//   wb_state_e  : controller states (idle, memory read, read done, drain)
//   wb_entry_t  : one buffered write {addr, data} at the default widths
package mem_write_buffer_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StRdone,
        StDrain
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mem_write_buffer_fifo.sv
// Circular FIFO holding posted writes.
//   clk, rst              : clock, asynchronous active-low reset
//   push, push_addr/data  : enqueue at tail (ignored when full)
//   pop                   : dequeue head (ignored when empty)
//   count, full, empty    : occupancy
//   head_addr/data        : oldest entry
//   entry_addr/data/valid : all entries in age order, slot 0 = oldest
module write_buffer_fifo
    import mem_write_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [DATA_W-1:0]        head_data,
    output logic [DEPTH*ADDR_W-1:0]  entry_addr,
    output logic [DEPTH*DATA_W-1:0]  entry_data,
    output logic [DEPTH-1:0]         entry_valid
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PtrW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) tail_q <= tail_q + PtrW'(1);
            if (do_pop)  head_q <= head_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[tail_q] <= push_addr;
            data_mem[tail_q] <= push_data;
        end
    end

    assign head_addr = addr_mem[head_q];
    assign head_data = data_mem[head_q];

    // Rotate storage so slot i is the i-th oldest entry; the forwarding
    // search then picks the youngest match by slot index alone.
    always_comb begin
        entry_addr  = '0;
        entry_data  = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i*ADDR_W +: ADDR_W] = addr_mem[head_q + PtrW'(i)];
            entry_data[i*DATA_W +: DATA_W] = data_mem[head_q + PtrW'(i)];
            entry_valid[i]                 = (CntW'(i) < count_q);
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the write-through cache and main memory.
//   clk, rst      : clock, asynchronous active-low reset
//   wb_*          : cache-side request port (addr, en_R, en_W, wdata, rdata, busy)
//   dram_*        : single req/ack memory port (req, we, addr, wdata, ack, rdata)
// Writes are absorbed into a FIFO; reads forward from the youngest matching
// entry or go to memory; reads and drains share the memory port.
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_en_R,
    input  logic              wb_en_W,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              wb_busy,
    output logic              dram_req,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic              dram_ack,
    input  logic [DATA_W-1:0] dram_rdata
);

    logic [$clog2(DEPTH):0]  count;
    logic                    full, empty;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [DEPTH*ADDR_W-1:0] entry_addr;
    logic [DEPTH*DATA_W-1:0] entry_data;
    logic [DEPTH-1:0]        entry_valid;
    logic                    push, pop;

    wb_state_e         state_q;
    logic [DATA_W-1:0] rd_buf_q;
    logic              dram_req_q, dram_we_q;
    logic [ADDR_W-1:0] dram_addr_q;
    logic [DATA_W-1:0] dram_wdata_q;

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    write_buffer_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (wb_addr),
        .push_data   (wb_wdata),
        .pop         (pop),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .entry_addr  (entry_addr),
        .entry_data  (entry_data),
        .entry_valid (entry_valid)
    );

    // Ascending scan: a later (younger) match overrides an older one.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i*ADDR_W +: ADDR_W] == wb_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Busy depends only on registered state and the FIFO count, never on dram_ack.
    always_comb begin
        wb_rdata = (fwd_hit && state_q != StRdone) ? fwd_data : rd_buf_q;
        if (wb_en_R) begin
            // A read in flight must not be satisfied by writes posted after it left.
            wb_busy = !((state_q == StRdone) || (fwd_hit && state_q != StRead));
        end else if (wb_en_W) begin
            wb_busy = full;
        end else begin
            wb_busy = 1'b0;
        end
    end

    assign push = wb_en_W && !wb_en_R && !full;
    assign pop  = (state_q == StDrain) && dram_ack && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            rd_buf_q     <= '0;
            dram_req_q   <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // A read miss may overtake pending writes: none match its address.
                    if (wb_en_R && !fwd_hit) begin
                        state_q     <= StRead;
                        dram_req_q  <= 1'b1;
                        dram_we_q   <= 1'b0;
                        dram_addr_q <= wb_addr;
                    end else if (count != '0) begin
                        state_q      <= StDrain;
                        dram_req_q   <= 1'b1;
                        dram_we_q    <= 1'b1;
                        dram_addr_q  <= head_addr;
                        dram_wdata_q <= head_data;
                    end
                end
                StRead: begin
                    if (dram_ack) begin
                        rd_buf_q   <= dram_rdata;
                        dram_req_q <= 1'b0;
                        state_q    <= StRdone;
                    end
                end
                StRdone: begin
                    state_q <= StIdle;
                end
                StDrain: begin
                    if (dram_ack) begin
                        dram_req_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dram_req   = dram_req_q;
    assign dram_we    = dram_we_q;
    assign dram_addr  = dram_addr_q;
    assign dram_wdata = dram_wdata_q;

endmodule
